// File: rtl/irq_seq.sv
// irq_seq: post-reset sequencer with a saturating cycle counter and NCH
// independent interrupt pulse generators. Each channel waits for a start
// cycle, emits `count` pulses of `width` cycles spaced `period` cycles apart
// (count = 0 repeats forever), then reports done.
//
// Handshake note: there is no valid/ready traffic here. cfg_we is a single-
// cycle write strobe, accepted on the edge it is sampled high, and only for a
// channel that is IDLE or DONE; otherwise the write is dropped silently.
//
// dbg_state exposes every channel FSM, 3 bits per channel:
// 0 IDLE, 1 WAIT, 2 PULSE, 3 GAP, 4 DONE.
module irq_seq #(
  parameter int NCH     = 2,
  parameter int CW      = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [CW-1:0]    cfg_wdata,
  input  logic [NCH-1:0]   enable,
  output logic             sys_reset_l,
  output logic [CW-1:0]    cycle,
  output logic [NCH-1:0]   irq,
  output logic [NCH-1:0]   done,
  output logic [3*NCH-1:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  logic [7:0]    rst_cnt_q, rst_cnt_d;
  logic          sys_rst_q, sys_rst_d;
  logic [CW-1:0] cycle_q, cycle_d;

  // Downstream reset stretch, then a cycle counter that sticks at all-ones.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    sys_rst_d = sys_rst_q;
    cycle_d   = cycle_q;
    if (!sys_rst_q) begin
      if (rst_cnt_q == 8'(RST_CYC - 1)) begin
        sys_rst_d = 1'b1;
      end else begin
        rst_cnt_d = rst_cnt_q + 8'd1;
      end
    end else if (cycle_q != '1) begin
      cycle_d = cycle_q + CW'(1);
    end
  end

  // Reset sequencer and cycle counter registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rst_cnt_q <= 8'd0;
      sys_rst_q <= 1'b0;
      cycle_q   <= '0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      sys_rst_q <= sys_rst_d;
      cycle_q   <= cycle_d;
    end
  end

  assign sys_reset_l = sys_rst_q;
  assign cycle       = cycle_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] start_q, start_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic          irq_q, irq_d;
    logic          done_q, done_d;
    logic [CW-1:0] gap_len;
    logic          cfg_open;

    // Gap is the rest of the period, but never shorter than one cycle.
    assign gap_len  = (period_q > width_q) ? (period_q - width_q) : CW'(1);
    assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Field writes and the channel FSM next-state; irq/done follow the next state.
    always_comb begin
      start_d  = start_q;
      width_d  = width_q;
      period_d = period_q;
      count_d  = count_q;
      rem_d    = rem_q;
      tmr_d    = tmr_q;
      state_d  = state_q;

      if (cfg_we && (cfg_ch == 3'(g)) && cfg_open) begin
        case (cfg_sel)
          2'd0:    start_d  = cfg_wdata;
          2'd1:    width_d  = cfg_wdata;
          2'd2:    period_d = cfg_wdata;
          default: count_d  = cfg_wdata;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (enable[g] && sys_rst_q) begin
            state_d = ST_WAIT;
            rem_d   = count_q;
          end
        end
        ST_WAIT: begin
          if (!enable[g]) begin
            state_d = ST_IDLE;
          end else if (cycle_q >= start_q) begin
            if (width_q == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_PULSE;
              tmr_d   = width_q;
            end
          end
        end
        ST_PULSE: begin
          if (!enable[g]) begin
            state_d = ST_IDLE;
          end else if (tmr_q == CW'(1)) begin
            if ((count_q == '0) || (rem_q > CW'(1))) begin
              state_d = ST_GAP;
              tmr_d   = gap_len;
              if (count_q != '0) rem_d = rem_q - CW'(1);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            tmr_d = tmr_q - CW'(1);
          end
        end
        ST_GAP: begin
          if (!enable[g]) begin
            state_d = ST_IDLE;
          end else if (tmr_q == CW'(1)) begin
            state_d = ST_PULSE;
            tmr_d   = width_q;
          end else begin
            tmr_d = tmr_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (!enable[g]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      irq_d  = (state_d == ST_PULSE);
      done_d = (state_d == ST_DONE);
    end

    // Channel state, fields and registered outputs.
    always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
        state_q  <= ST_IDLE;
        start_q  <= '0;
        width_q  <= '0;
        period_q <= '0;
        count_q  <= '0;
        rem_q    <= '0;
        tmr_q    <= '0;
        irq_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        start_q  <= start_d;
        width_q  <= width_d;
        period_q <= period_d;
        count_q  <= count_d;
        rem_q    <= rem_d;
        tmr_q    <= tmr_d;
        irq_q    <= irq_d;
        done_q   <= done_d;
      end
    end

    assign irq[g]              = irq_q;
    assign done[g]             = done_q;
    assign dbg_state[3*g +: 3] = state_q;
  end

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: main instance with default parameters plus a
// small instance (CW=4, RST_CYC=1) to reach cycle saturation quickly.
module tb_irq_seq;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_wdata;
  logic [1:0]  enable;
  logic        sys_reset_l;
  logic [15:0] cycle;
  logic [1:0]  irq;
  logic [1:0]  done;
  logic [5:0]  dbg_state;

  logic        sys_reset_s;
  logic [3:0]  cycle_s;
  logic [0:0]  irq_s;
  logic [0:0]  done_s;
  logic [2:0]  dbg_s;
  logic        cfg_we_s = 1'b0;
  logic [2:0]  cfg_ch_s = 3'd0;
  logic [1:0]  cfg_sel_s = 2'd0;
  logic [3:0]  cfg_wdata_s = 4'd0;
  logic [0:0]  enable_s = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic irq1_seen = 1'b0;

  // Clock
  always #5 clk = ~clk;

  irq_seq dut (
    .clk(clk), .reset_l(reset_l), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .enable(enable),
    .sys_reset_l(sys_reset_l), .cycle(cycle), .irq(irq), .done(done),
    .dbg_state(dbg_state)
  );

  irq_seq #(.NCH(1), .CW(4), .RST_CYC(1)) dut_s (
    .clk(clk), .reset_l(reset_l), .cfg_we(cfg_we_s), .cfg_ch(cfg_ch_s),
    .cfg_sel(cfg_sel_s), .cfg_wdata(cfg_wdata_s), .enable(enable_s),
    .sys_reset_l(sys_reset_s), .cycle(cycle_s), .irq(irq_s), .done(done_s),
    .dbg_state(dbg_s)
  );

  always @(negedge clk) if (irq[1] === 1'b1) irq1_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] ch, input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_to(input string tag, input logic [15:0] target);
    int n = 0;
    while (cycle !== target && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, cycle, target);
  endtask

  task automatic do_reset();
    reset_l = 1'b0; enable = 2'b00; cfg_we = 1'b0;
    tick();
    reset_l = 1'b1;
    tick();
    chk("rst_hold", sys_reset_l, 1'b0);
    tick();
    chk("rst_rel", sys_reset_l, 1'b1);
    chk("rst_cycle0", cycle, 16'd0);
  endtask

  initial begin
    reset_l = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_sel = 2'd0;
    cfg_wdata = 16'd0; enable = 2'b00;

    // Reset state
    tick();
    chk("reset_sys", sys_reset_l, 1'b0);
    chk("reset_cycle", cycle, 16'd0);
    chk("reset_irq", irq, 2'b00);
    chk("reset_done", done, 2'b00);
    chk("reset_state", dbg_state, 6'd0);

    // Release: RST_CYC=2 on main, 1 on the small instance
    reset_l = 1'b1;
    tick();
    chk("rel_e1_sys", sys_reset_l, 1'b0);
    chk("rel_e1_sys_s", sys_reset_s, 1'b1);
    chk("rel_e1_cycle_s", cycle_s, 4'd0);
    tick();
    chk("rel_e2_sys", sys_reset_l, 1'b1);
    chk("rel_e2_cycle", cycle, 16'd0);
    chk("rel_e2_cycle_s", cycle_s, 4'd1);
    tick();
    chk("rel_e3_cycle", cycle, 16'd1);

    // Single pulse on ch0, width-0 channel on ch1
    cfg_wr(3'd0, 2'd0, 16'd200);
    cfg_wr(3'd0, 2'd1, 16'd3);
    cfg_wr(3'd0, 2'd3, 16'd1);
    cfg_wr(3'd1, 2'd0, 16'd10);
    enable = 2'b11;
    tick();
    chk("both_wait", dbg_state, {S_WAIT, S_WAIT});
    run_to("to_10", 16'd10);
    chk("ch1_not_done", done, 2'b00);
    tick();
    chk("ch1_done", done, 2'b10);
    chk("ch1_state", dbg_state, {S_DONE, S_WAIT});
    run_to("to_200", 16'd200);
    chk("c200_irq", irq, 2'b00);
    tick();
    chk("c201_irq", irq, 2'b01);
    tick();
    chk("c202_irq", irq, 2'b01);
    tick();
    chk("c203_irq", irq, 2'b01);
    chk("c203_cycle", cycle, 16'd203);
    tick();
    chk("c204_irq", irq, 2'b00);
    chk("c204_done", done, 2'b11);
    chk("ch1_never_irq", irq1_seen, 1'b0);
    chk("sat_cycle_s", cycle_s, 4'd15);

    // DONE returns to IDLE when enable drops
    enable = 2'b00;
    tick();
    chk("done_clear", done, 2'b00);
    chk("idle_again", dbg_state, {S_IDLE, S_IDLE});

    // Two pulses 200 cycles apart
    do_reset();
    cfg_wr(3'd0, 2'd0, 16'd200);
    cfg_wr(3'd0, 2'd1, 16'd3);
    cfg_wr(3'd0, 2'd2, 16'd200);
    cfg_wr(3'd0, 2'd3, 16'd2);
    enable = 2'b01;
    run_to("p1_to_200", 16'd200);
    chk("p1_pre", irq, 2'b00);
    tick();
    chk("p1_201", irq, 2'b01);
    run_to("p1_to_203", 16'd203);
    chk("p1_203", irq, 2'b01);
    tick();
    chk("p1_204", irq, 2'b00);
    chk("p1_gap_state", dbg_state[2:0], S_GAP);
    chk("p1_gap_done", done, 2'b00);
    run_to("p2_to_400", 16'd400);
    chk("p2_pre", irq, 2'b00);
    tick();
    chk("p2_401", irq, 2'b01);
    run_to("p2_to_403", 16'd403);
    chk("p2_403", irq, 2'b01);
    tick();
    chk("p2_404_irq", irq, 2'b00);
    chk("p2_404_done", done, 2'b01);

    // Infinite alternating pulses, ignored cfg write, disable mid-pulse
    do_reset();
    cfg_wr(3'd0, 2'd1, 16'd1);
    cfg_wr(3'd0, 2'd2, 16'd1);
    enable = 2'b01;
    tick();
    chk("alt_wait", dbg_state[2:0], S_WAIT);
    tick();
    chk("alt_p1", irq, 2'b01);
    tick();
    chk("alt_g1", irq, 2'b00);
    tick();
    chk("alt_p2", irq, 2'b01);
    cfg_wr(3'd0, 2'd1, 16'd5);
    chk("alt_g2", irq, 2'b00);
    tick();
    chk("alt_p3", irq, 2'b01);
    tick();
    chk("alt_width_kept", irq, 2'b00);
    tick();
    chk("alt_p4", irq, 2'b01);
    enable = 2'b00;
    tick();
    chk("dis_irq", irq, 2'b00);
    chk("dis_done", done, 2'b00);
    chk("dis_state", dbg_state[2:0], S_IDLE);

    // Asynchronous reset mid-pulse clears fields
    enable = 2'b01;
    tick();
    tick();
    chk("re_pulse", irq, 2'b01);
    reset_l = 1'b0;
    #1;
    chk("arst_irq", irq, 2'b00);
    chk("arst_done", done, 2'b00);
    chk("arst_cycle", cycle, 16'd0);
    chk("arst_sys", sys_reset_l, 1'b0);
    chk("arst_state", dbg_state, 6'd0);
    @(negedge clk);
    reset_l = 1'b1;
    tick();
    chk("arel_e1_sys", sys_reset_l, 1'b0);
    tick();
    chk("arel_e2_state", dbg_state[2:0], S_IDLE);
    tick();
    chk("arel_e3_state", dbg_state[2:0], S_WAIT);
    chk("arel_e3_done", done, 2'b00);
    tick();
    chk("arel_e4_done", done, 2'b01);
    chk("arel_e4_irq", irq, 2'b00);
    enable = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_seq.md
IRQ_SEQ -- requirements
Module: irq_seq

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent interrupt channels (1..8).
REQ-002 SHALL have parameter CW, default 16, width of the cycle counter and all timing fields.
REQ-003 SHALL have parameter RST_CYC, default 2, number of cycles sys_reset_l is held low after reset release (1..255).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset_l  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  configuration write strobe, one write per cycle.
REQ-007 cfg_ch  in  3  target channel; values >= NCH ignored.
REQ-008 cfg_sel  in  2  field select: 0 start, 1 width, 2 period, 3 count.
REQ-009 cfg_wdata  in  CW  field write data.
REQ-010 enable  in  NCH  per-channel run enable, level-sensitive.
REQ-011 sys_reset_l  out  1  registered, active-low reset for the downstream system.
REQ-012 cycle  out  CW  cycles elapsed since sys_reset_l released.
REQ-013 irq  out  NCH  registered interrupt pulses, active high.
REQ-014 done  out  NCH  per-channel sequence complete, active high.

Function
REQ-015 SHALL hold sys_reset_l low for exactly RST_CYC clk edges after reset_l deasserts, then high until next reset_l.
REQ-016 cycle SHALL be 0 in the first cycle sys_reset_l is high, increment by 1 per clk, saturate at 2^CW-1 (no wrap).
REQ-017 SHALL keep per-channel fields start, width, period, count (CW bits each); reset value 0.
REQ-018 A cfg write SHALL update the field on the next edge only if the channel is IDLE or DONE; otherwise ignored.
REQ-019 Per-channel FSM states: IDLE, WAIT, PULSE, GAP, DONE; reset state IDLE.
REQ-020 IDLE -> WAIT when enable[ch]=1 and sys_reset_l=1; remaining-pulse counter loads count.
REQ-021 WAIT -> PULSE on the edge where cycle >= start; WAIT -> DONE instead if width = 0.
REQ-022 irq[ch] SHALL be 1 exactly in PULSE cycles; PULSE lasts width cycles.
REQ-023 End of PULSE: count=0 (infinite) or remaining>1 -> GAP, decrement remaining unless infinite; remaining=1 -> DONE.
REQ-024 GAP lasts max(period-width, 1) cycles, then -> PULSE; pulse starts are thus period cycles apart when period > width.
REQ-025 DONE: done[ch]=1, irq[ch]=0; DONE -> IDLE when enable[ch]=0.
REQ-026 enable[ch]=0 in WAIT, PULSE or GAP -> IDLE on next edge; irq[ch] low from that edge; done[ch] stays 0.
REQ-027 Channels SHALL be fully independent; simultaneous pulses on several channels allowed.
REQ-028 cycle saturated and start not reached: channel SHALL remain in WAIT indefinitely.

Reset
REQ-029 reset_l low SHALL immediately force sys_reset_l=0, cycle=0, irq=0, done=0, all FSMs IDLE, all fields 0, including mid-pulse.
REQ-030 No output SHALL glitch high during or on release of reset_l.

Verification
V-1 RST_CYC=2, release reset_l -> sys_reset_l low for 2 edges, high after; cycle=0 first high cycle.
V-2 ch0 start=200 width=3 count=1, enable -> irq[0] high while cycle in 201..203, done[0] from cycle 204.
V-3 ch0 start=200 width=3 period=200 count=2 -> pulses at cycle 201..203 and 401..403, then done[0].
V-4 ch1 width=0 start=10 -> irq[1] never asserts, done[1]=1 after cycle 10; ch0 unaffected.
V-5 count=0 width=1 period=1 -> irq alternates 1,0 forever; deassert enable mid-pulse -> irq 0 next edge, IDLE.
V-6 assert reset_l low during PULSE -> irq, done, cycle 0 asynchronously; cfg write during PULSE has no effect.
